// File: rtl/alu_issue.sv
// ID/EX issue register for the integer ALU: decodes the ALU control code in ID,
// registers the instruction into EX, and forwards EX/MEM and MEM/WB results onto the EX operands.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [1:0]  id_alu_op,
    input  logic [5:0]  id_funct,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic        id_alu_src,
    input  logic        exmem_reg_write,
    input  logic        memwb_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_data,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_illegal,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_data1,
    output logic [31:0] ex_data2,
    output logic [31:0] ex_store_data,
    output logic [3:0]  ex_alu_control
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    localparam logic [CW-1:0] CTL_AND = 4'b0000;
    localparam logic [CW-1:0] CTL_OR  = 4'b0001;
    localparam logic [CW-1:0] CTL_ADD = 4'b0010;
    localparam logic [CW-1:0] CTL_SUB = 4'b0110;
    localparam logic [CW-1:0] CTL_SLT = 4'b0111;
    localparam logic [CW-1:0] CTL_NOR = 4'b1100;
    localparam logic [CW-1:0] CTL_XOR = 4'b1101;

    localparam logic [RW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic          valid;
        logic [CW-1:0] alu_control;
        logic          illegal;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic          reg_write;
        logic          alu_src;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
    } ex_t;

    localparam ex_t BUBBLE = '{
        valid:       1'b0,
        alu_control: CTL_ADD,
        illegal:     1'b0,
        rs:          '0,
        rt:          '0,
        rd:          '0,
        reg_write:   1'b0,
        alu_src:     1'b0,
        rs_data:     '0,
        rt_data:     '0,
        imm:         '0
    };

    logic [CW-1:0] dec_ctrl;
    logic          dec_illegal;
    ex_t           id_pkt;
    ex_t           ex_d;
    ex_t           ex_q;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // ALU control decode; unknown encodings still issue as add but are flagged
    always_comb begin
        dec_ctrl    = CTL_ADD;
        dec_illegal = 1'b0;
        case (id_alu_op)
            2'b00: dec_ctrl = CTL_ADD;
            2'b01: dec_ctrl = CTL_SUB;
            2'b10: begin
                case (id_funct)
                    6'h20, 6'h21: dec_ctrl = CTL_ADD;
                    6'h22, 6'h23: dec_ctrl = CTL_SUB;
                    6'h24:        dec_ctrl = CTL_AND;
                    6'h25:        dec_ctrl = CTL_OR;
                    6'h26:        dec_ctrl = CTL_XOR;
                    6'h27:        dec_ctrl = CTL_NOR;
                    6'h2A:        dec_ctrl = CTL_SLT;
                    default:      dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (id_opcode)
                    6'h08, 6'h09: dec_ctrl = CTL_ADD;
                    6'h0C:        dec_ctrl = CTL_AND;
                    6'h0D:        dec_ctrl = CTL_OR;
                    6'h0E:        dec_ctrl = CTL_XOR;
                    6'h0A:        dec_ctrl = CTL_SLT;
                    default:      dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Packet presented by ID; an empty ID slot becomes a bubble
    always_comb begin
        id_pkt = BUBBLE;
        if (id_valid) begin
            id_pkt.valid       = 1'b1;
            id_pkt.alu_control = dec_ctrl;
            id_pkt.illegal     = dec_illegal;
            id_pkt.rs          = id_rs;
            id_pkt.rt          = id_rt;
            id_pkt.rd          = id_rd;
            id_pkt.reg_write   = id_reg_write;
            id_pkt.alu_src     = id_alu_src;
            id_pkt.rs_data     = id_rs_data;
            id_pkt.rt_data     = id_rt_data;
            id_pkt.imm         = id_imm;
        end
    end

    // Flush beats stall beats load
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = BUBBLE;
        end else if (!stall) begin
            ex_d = id_pkt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Forwarding: youngest producer wins, register 0 is never bypassed
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (exmem_reg_write && (exmem_rd != REG_ZERO) && (exmem_rd == ex_q.rs)) begin
            fwd_rs = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != REG_ZERO) && (memwb_rd == ex_q.rs)) begin
            fwd_rs = memwb_data;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (exmem_reg_write && (exmem_rd != REG_ZERO) && (exmem_rd == ex_q.rt)) begin
            fwd_rt = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != REG_ZERO) && (memwb_rd == ex_q.rt)) begin
            fwd_rt = memwb_data;
        end
    end

    assign ex_valid       = ex_q.valid;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_illegal     = ex_q.illegal;
    assign ex_rd          = ex_q.rd;
    assign ex_alu_control = ex_q.alu_control;
    assign ex_data1       = fwd_rs;
    assign ex_store_data  = fwd_rt;
    assign ex_data2       = ex_q.alu_src ? ex_q.imm : fwd_rt;

endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue: a reference model predicts the EX view
// after every clock edge, and a monitor compares it against the DUT.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct, id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_reg_write, id_alu_src;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_data;
    logic        ex_valid, ex_reg_write, ex_illegal;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data1, ex_data2, ex_store_data;
    logic [3:0]  ex_alu_control;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .exmem_reg_write(exmem_reg_write),
        .memwb_reg_write(memwb_reg_write), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_result(exmem_result), .memwb_data(memwb_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal),
        .ex_rd(ex_rd), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_store_data(ex_store_data), .ex_alu_control(ex_alu_control)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, valid;
        logic [1:0]  alu_op;
        logic [5:0]  funct, opcode;
        logic [4:0]  rs, rt, rd;
        logic        rw, src;
        logic [31:0] rsd, rtd, imm;
        logic        xw, ww;
        logic [4:0]  xrd, wrd;
        logic [31:0] xres, wdat;
    } stim_t;

    // Instruction currently sitting in EX, as the model sees it
    typedef struct {
        bit        valid, ill, rw, src;
        bit [3:0]  ctl;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rsd, rtd, imm;
    } slot_t;

    typedef struct {
        logic        valid, rw, ill;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic [31:0] d1, d2, sd;
    } exp_t;

    slot_t m;
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic slot_t bubble();
        slot_t b;
        b = '{default: 0};
        b.ctl = 4'b0010;
        return b;
    endfunction

    // ALU control per the opcode/funct tables; anything unlisted is add + illegal
    function automatic void decode_ref(input stim_t s, output bit [3:0] ctl, output bit ill);
        ill = 0;
        ctl = 4'b0010;
        if (s.alu_op == 2'b01) ctl = 4'b0110;
        else if (s.alu_op == 2'b10) begin
            if (s.funct inside {6'h20, 6'h21})      ctl = 4'b0010;
            else if (s.funct inside {6'h22, 6'h23}) ctl = 4'b0110;
            else if (s.funct == 6'h24)              ctl = 4'b0000;
            else if (s.funct == 6'h25)              ctl = 4'b0001;
            else if (s.funct == 6'h26)              ctl = 4'b1101;
            else if (s.funct == 6'h27)              ctl = 4'b1100;
            else if (s.funct == 6'h2A)              ctl = 4'b0111;
            else ill = 1;
        end else if (s.alu_op == 2'b11) begin
            if (s.opcode inside {6'h08, 6'h09})     ctl = 4'b0010;
            else if (s.opcode == 6'h0C)             ctl = 4'b0000;
            else if (s.opcode == 6'h0D)             ctl = 4'b0001;
            else if (s.opcode == 6'h0E)             ctl = 4'b1101;
            else if (s.opcode == 6'h0A)             ctl = 4'b0111;
            else ill = 1;
        end
    endfunction

    function automatic logic [31:0] fwd_ref(bit [4:0] r, bit [31:0] own, stim_t s);
        if (r == 0) return own;
        if (s.xw && s.xrd == r) return s.xres;
        if (s.ww && s.wrd == r) return s.wdat;
        return own;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        bit [5:0] functs[8] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
        bit [5:0] opcs[6]   = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A};
        s.stall  = ($urandom_range(0, 5) == 0);
        s.flush  = ($urandom_range(0, 7) == 0);
        s.valid  = ($urandom_range(0, 5) != 0);
        s.alu_op = 2'($urandom_range(0, 3));
        s.funct  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 7)];
        s.opcode = ($urandom_range(0, 4) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 5)];
        s.rs     = 5'($urandom_range(0, 3));
        s.rt     = 5'($urandom_range(0, 3));
        s.rd     = 5'($urandom);
        s.rw     = 1'($urandom);
        s.src    = 1'($urandom);
        s.rsd    = $urandom;
        s.rtd    = $urandom;
        s.imm    = $urandom;
        s.xw     = 1'($urandom);
        s.ww     = 1'($urandom);
        s.xrd    = 5'($urandom_range(0, 3));
        s.wrd    = 5'($urandom_range(0, 3));
        s.xres   = $urandom;
        s.wdat   = $urandom;
        return s;
    endfunction

    // Drive one cycle, advance the model across the coming edge, queue the expected EX view
    task automatic apply(stim_t s);
        exp_t e;
        bit [3:0] ctl;
        bit ill;
        @(negedge clk);
        rst_n = 1'b1;
        stall = s.stall; flush = s.flush; id_valid = s.valid;
        id_alu_op = s.alu_op; id_funct = s.funct; id_opcode = s.opcode;
        id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_reg_write = s.rw;
        id_rs_data = s.rsd; id_rt_data = s.rtd; id_imm = s.imm; id_alu_src = s.src;
        exmem_reg_write = s.xw; memwb_reg_write = s.ww; exmem_rd = s.xrd; memwb_rd = s.wrd;
        exmem_result = s.xres; memwb_data = s.wdat;
        if (s.flush) m = bubble();
        else if (!s.stall) begin
            if (!s.valid) m = bubble();
            else begin
                decode_ref(s, ctl, ill);
                m = '{valid: 1, ill: ill, rw: s.rw, src: s.src, ctl: ctl, rs: s.rs, rt: s.rt,
                      rd: s.rd, rsd: s.rsd, rtd: s.rtd, imm: s.imm};
            end
        end
        e.valid = m.valid;
        e.rw    = m.rw;
        e.ill   = m.ill;
        e.rd    = m.rd;
        e.ctl   = m.ctl;
        e.d1    = fwd_ref(m.rs, m.rsd, s);
        e.sd    = fwd_ref(m.rt, m.rtd, s);
        e.d2    = m.src ? m.imm : e.sd;
        sb.push_back(e);
    endtask

    // Assert reset mid-cycle and confirm the bubble appears with no clock edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        m = bubble();
        #1;
        chk("rst_valid", 32'(ex_valid), 32'(0));
        chk("rst_ctl", 32'(ex_alu_control), 32'(4'b0010));
        chk("rst_data1", ex_data1, 32'h0);
        chk("rst_data2", ex_data2, 32'h0);
        chk("rst_regwrite", 32'(ex_reg_write), 32'(0));
        @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(ex_valid), 32'(0));
    endtask

    // Monitor: after every edge, compare the DUT against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid", 32'(ex_valid), 32'(e.valid));
                chk("reg_write", 32'(ex_reg_write), 32'(e.rw));
                chk("illegal", 32'(ex_illegal), 32'(e.ill));
                chk("rd", 32'(ex_rd), 32'(e.rd));
                chk("alu_control", 32'(ex_alu_control), 32'(e.ctl));
                chk("data1", ex_data1, e.d1);
                chk("data2", ex_data2, e.d2);
                chk("store_data", ex_store_data, e.sd);
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        stall = 0; flush = 0; id_valid = 0; id_alu_op = 0; id_funct = 0; id_opcode = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_reg_write = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm = 0; id_alu_src = 0; exmem_reg_write = 0; memwb_reg_write = 0;
        exmem_rd = 0; memwb_rd = 0; exmem_result = 0; memwb_data = 0;
        m = bubble();
        repeat (2) @(posedge clk);

        // NOR decode with plain operands
        s = idle(); s.valid = 1; s.alu_op = 2'b10; s.funct = 6'h27; s.rs = 1; s.rt = 2; s.rd = 3;
        s.rw = 1; s.rsd = 32'h0F0F_0000; s.rtd = 32'h00FF_00FF;
        apply(s);

        // Reset with a live instruction in EX, then load normally
        do_reset();
        s = idle(); s.valid = 1; s.alu_op = 2'b10; s.funct = 6'h3F; s.rs = 7; s.rt = 8; s.rd = 9;
        s.rw = 1; s.rsd = 32'h1111; s.rtd = 32'h2222;
        apply(s);

        // EX/MEM beats MEM/WB on rs=5, then MEM/WB alone
        s = idle(); s.valid = 1; s.alu_op = 2'b00; s.rs = 5; s.rt = 6; s.rd = 4; s.rw = 1;
        s.rsd = 32'hAAAA; s.rtd = 32'hBBBB;
        apply(s);
        s.stall = 1; s.xw = 1; s.xrd = 5; s.xres = 32'h11; s.ww = 1; s.wrd = 5; s.wdat = 32'h22;
        apply(s);
        s.xw = 0;
        apply(s);

        // Register 0 is never forwarded
        s = idle(); s.valid = 1; s.alu_op = 2'b01; s.rs = 3; s.rt = 0; s.rd = 1; s.rw = 1;
        s.rsd = 32'h5; s.rtd = 32'h0000_1234;
        apply(s);
        s.stall = 1; s.xw = 1; s.xrd = 0; s.xres = 32'hDEAD_BEEF; s.ww = 1; s.wrd = 0;
        s.wdat = 32'hCAFE_F00D;
        apply(s);

        // addi, two stall cycles with changing ID, then stall+flush
        s = idle(); s.valid = 1; s.alu_op = 2'b11; s.opcode = 6'h08; s.rs = 2; s.rt = 9; s.rd = 9;
        s.rw = 1; s.src = 1; s.imm = 32'd4; s.rsd = 32'h100;
        apply(s);
        for (int i = 0; i < 2; i++) begin
            s = rnd_stim(); s.stall = 1; s.flush = 0; s.xw = 0; s.ww = 0;
            apply(s);
        end
        s = rnd_stim(); s.stall = 1; s.flush = 1;
        apply(s);

        // Reset while stalled, then random traffic
        s = idle(); s.valid = 1; s.alu_op = 2'b10; s.funct = 6'h2A; s.rs = 1; s.rt = 2; s.rd = 3;
        s.rw = 1; s.rsd = 32'h3; s.rtd = 32'h4;
        apply(s);
        s.stall = 1;
        apply(s);
        do_reset();
        for (int i = 0; i < 400; i++) begin
            apply(rnd_stim());
            if (i == 200) do_reset();
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low; one clock only.
REQ-003 stall  input  1  hold EX register contents this cycle.
REQ-004 flush  input  1  load a bubble into the EX register this cycle.
REQ-005 id_valid  input  1  ID stage holds a real instruction.
REQ-006 id_alu_op  input  2  00 add, 01 subtract, 10 R-type (use funct), 11 I-type (use opcode).
REQ-007 id_funct, id_opcode  input  6 each  instruction fields.
REQ-008 id_rs, id_rt, id_rd  input  5 each  register numbers; id_reg_write  input  1.
REQ-009 id_rs_data, id_rt_data, id_imm  input  32 each  register-file reads, sign-extended immediate.
REQ-010 id_alu_src  input  1  1 selects immediate as ALU operand 2.
REQ-011 exmem_reg_write, memwb_reg_write  input  1 each; exmem_rd, memwb_rd  input  5 each; exmem_result, memwb_data  input  32 each  forwarding sources.
REQ-012 ex_valid, ex_reg_write, ex_illegal  output  1 each; ex_rd  output  5.
REQ-013 ex_data1, ex_data2, ex_store_data  output  32 each  ALU operands and forwarded rt for stores.
REQ-014 ex_alu_control  output  4  ALU control code: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 SLT, 1100 NOR, 1101 XOR.

Function
REQ-015 Decode in ID, register at clk: alu_op 00 -> 0010; 01 -> 0110.
REQ-016 alu_op 10, funct: 0x20/0x21 -> 0010; 0x22/0x23 -> 0110; 0x24 -> 0000; 0x25 -> 0001; 0x26 -> 1101; 0x27 -> 1100; 0x2A -> 0111; other -> 0010 with illegal=1.
REQ-017 alu_op 11, opcode: 0x08/0x09 -> 0010; 0x0C -> 0000; 0x0D -> 0001; 0x0E -> 1101; 0x0A -> 0111; other -> 0010 with illegal=1.
REQ-018 Registered fields: valid, alu_control, illegal, rs, rt, rd, reg_write, alu_src, rs_data, rt_data, imm; one-cycle latency ID to EX.
REQ-019 Priority per edge: flush > stall > load; flush writes bubble even when stall=1.
REQ-020 Bubble: valid=0, reg_write=0, illegal=0, alu_control=0010, rs=rt=rd=0, all data 0.
REQ-021 id_valid=0 loads a bubble.
REQ-022 Stall: all registers hold; forwarding outputs still re-evaluate from current exmem/memwb inputs.
REQ-023 Forwarding combinational on registered rs/rt: EX/MEM match (reg_write=1, rd!=0, rd==src) selects exmem_result; else MEM/WB match selects memwb_data; else registered data.
REQ-024 EX/MEM has priority over MEM/WB when both match.
REQ-025 Register 0 never forwarded; ex_data1 for rs=0 is registered rs_data.
REQ-026 ex_store_data = forwarded rt value; ex_data2 = imm if alu_src=1 else forwarded rt.
REQ-027 Forwarding applies regardless of ex_valid; bubbles forward nothing since rs=rt=0.
REQ-028 ex_illegal is informational; instruction still issues with add semantics.

Reset
REQ-029 rst_n low forces EX register to bubble state (REQ-020) immediately, independent of clk.
REQ-030 Reset mid-stall or mid-flush discards held instruction; first edge after release loads ID normally.

Verification
REQ-031 Reset: rst_n=0 between edges -> ex_valid=0, ex_alu_control=0010, ex_data1=ex_data2=0 without clk edge.
REQ-032 Decode: alu_op=10, funct=0x27, rs_data=0x0F0F0000, rt_data=0x00FF00FF -> next cycle ex_alu_control=1100, ex_data1=0x0F0F0000, ex_data2=0x00FF00FF, ex_illegal=0.
REQ-033 Forward priority: ex_rs=5, exmem_rd=5/result=0x11, memwb_rd=5/data=0x22, both reg_write=1 -> ex_data1=0x11; drop exmem_reg_write -> 0x22.
REQ-034 Zero reg: ex_rt=0, exmem_rd=0, exmem_reg_write=1, result=0xDEADBEEF -> ex_data2 = registered rt_data, not 0xDEADBEEF.
REQ-035 Stall/flush: load addi (0x08, imm=4, alu_src=1) -> ex_data2=4; stall=1 two cycles -> held; stall=1 and flush=1 -> ex_valid=0, ex_reg_write=0.
REQ-036 Illegal: alu_op=10, funct=0x3F -> ex_alu_control=0010, ex_illegal=1, ex_valid=1.
